// File: rtl/message_route_scheduler.sv
// message_route_scheduler
// Round-robin scheduler for a 4-source / 4-destination message fabric.
// A rising edge on req[i] queues one transfer for source i. Pending sources
// are served in round-robin order starting after the last served source.
// Each transfer then runs through four phases:
//   - a setup cycle that drives grant and both selects,
//   - HOLD_CYCLES cycles with route_en high,
//   - a one-cycle done pulse,
//   - at least one idle cycle before the next grant.
// Every output comes straight from a flop.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   req[3:0]   per-source request; a rising edge queues one transfer
//   dest[7:0]  destination of source i on dest[2i+1:2i], sampled at arbitration
//   mux_sel    granted source index (4:1 source mux select)
//   demux_sel  destination index (1:4 destination demux select)
//   route_en   mux/demux enable, high only during the hold phase
//   grant      one-hot granted source, zero when idle
//   busy       high from grant through done
//   done       one-cycle pulse ending each transfer
module message_route_scheduler #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [7:0] dest,
    output logic [1:0] mux_sel,
    output logic [1:0] demux_sel,
    output logic       route_en,
    output logic [3:0] grant,
    output logic       busy,
    output logic       done
);
    // A hold length of 0 is treated as 1.
    localparam logic [7:0] HOLD_LOAD = (HOLD_CYCLES < 1) ? 8'd1 : 8'(HOLD_CYCLES);

    typedef enum logic [1:0] {IDLE, GRANT, HOLD, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] req_q, pend_q, pend_d, clr, edge_v;
    logic       prim_q;
    logic [1:0] ptr_q, ptr_d, win_q, win_d, dst_q, dst_d, pick, idx;
    logic       found;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] grant_q, grant_d;
    logic       route_en_q, route_en_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        // req_q is zero out of reset. The first sample after release is
        // therefore ignored, so that a level held through reset is not
        // mistaken for a new edge.
        edge_v = prim_q ? (req & ~req_q) : 4'b0;

        // Round-robin scan: ptr+1, ptr+2, ptr+3, then ptr.
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        dst_d   = dst_q;
        ptr_d   = ptr_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = GRANT;
                    win_d      = pick;
                    dst_d      = dest[{pick, 1'b0} +: 2];
                    clr[pick]  = 1'b1;
                end
            end
            GRANT: begin
                state_d = HOLD;
                cnt_d   = HOLD_LOAD;
            end
            HOLD: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = win_q;
            end
            default: state_d = IDLE;
        endcase

        // A new edge on the source being granted wins over its clear.
        pend_d = (pend_q & ~clr) | edge_v;

        // Outputs are registered from the next state, so they line up with it.
        grant_d    = (state_d != IDLE) ? (4'b0001 << win_d) : 4'b0;
        route_en_d = (state_d == HOLD);
        done_d     = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            req_q      <= '0;
            prim_q     <= 1'b0;
            pend_q     <= '0;
            ptr_q      <= 2'd3;
            cnt_q      <= '0;
            win_q      <= '0;
            dst_q      <= '0;
            grant_q    <= '0;
            route_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req;
            prim_q     <= 1'b1;
            pend_q     <= pend_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            dst_q      <= dst_d;
            grant_q    <= grant_d;
            route_en_q <= route_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The selects are the latched winner and destination. They only change
    // at arbitration, so they hold their values through a transfer and while idle.
    assign mux_sel   = win_q;
    assign demux_sel = dst_q;
    assign route_en  = route_en_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/message_route_scheduler.md
MESSAGE_ROUTE_SCHEDULER -- requirements
Module: message_route_scheduler

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of cycles route_en is held per transfer; legal range 1..255; 0 SHALL behave as 1.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-source request; bit i = source i; a rising edge registers one request.
REQ-005 Port: dest  input  8  destination of source i on dest[2i+1:2i]; sampled only at arbitration.
REQ-006 Port: mux_sel  output  2  index of granted source; drives the 4:1 source mux select.
REQ-007 Port: demux_sel  output  2  destination index; drives the 1:4 destination demux select.
REQ-008 Port: route_en  output  1  active-high enable for mux and demux; high only while routing.
REQ-009 Port: grant  output  4  one-hot granted source; all-zero when none.
REQ-010 Port: busy  output  1  high while a transfer is in progress.
REQ-011 Port: done  output  1  one-cycle pulse at the end of each transfer.

Function
REQ-012 Edge detect: req_q registers req each cycle; edge = req & ~req_q; a held-high req SHALL produce exactly one request.
REQ-013 pending[3:0]: bit i set at the edge where edge[i]=1; cleared at the edge where source i wins arbitration; set and clear in the same cycle -> set wins.
REQ-014 States: IDLE, GRANT, HOLD, DONE; one transition per clock, no other states.
REQ-015 IDLE: if pending != 0 -> GRANT; winner = first set pending bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); latch winner index and dest[2w+1:2w]; clear pending[w].
REQ-016 GRANT: grant = one-hot(w), mux_sel = w, demux_sel = latched dest, route_en = 0 (setup cycle); load hold counter with HOLD_CYCLES; -> HOLD.
REQ-017 HOLD: route_en = 1; counter decrements each cycle; -> DONE on the cycle counter equals 1; route_en high for exactly HOLD_CYCLES consecutive cycles.
REQ-018 DONE: route_en = 0, done = 1, grant still = one-hot(w); ptr <= w; -> IDLE.
REQ-019 IDLE outputs: grant = 0, route_en = 0, done = 0; mux_sel/demux_sel hold last values.
REQ-020 busy = 1 in GRANT, HOLD, DONE; 0 in IDLE.
REQ-021 mux_sel, demux_sel SHALL be constant from GRANT through DONE; dest changes during a transfer have no effect.
REQ-022 Latency: req rises before edge k -> pending set at k -> GRANT after k+1 -> route_en high after k+2 .. k+1+HOLD_CYCLES -> done after k+2+HOLD_CYCLES -> IDLE after k+3+HOLD_CYCLES.
REQ-023 Back-to-back: with further pending requests, next GRANT follows one IDLE cycle; done-to-done spacing = HOLD_CYCLES + 3 cycles.
REQ-024 A new edge from the source currently granted SHALL set its pending bit and be served in a later turn under round-robin order.
REQ-025 All outputs SHALL be registered (no combinational path from req/dest to outputs).

Reset
REQ-026 reset = 1 SHALL immediately force: state IDLE, pending = 0, req_q = 0, ptr = 3, counter = 0, mux_sel = 0, demux_sel = 0, route_en = 0, grant = 0, busy = 0, done = 0.
REQ-027 Reset mid-transfer SHALL abort it with no done pulse; after release no transfer occurs without a new req edge.
REQ-028 After reset, source 0 has highest priority (ptr = 3).

Verification
REQ-029 Reset: assert reset in any state -> all outputs 0 within the same cycle, IDLE after release.
REQ-030 Single: HOLD_CYCLES=4, dest[5:4]=1, pulse req[2] -> grant=0100, mux_sel=2, demux_sel=1 two edges later; route_en high 4 cycles; done one pulse; busy 6 cycles.
REQ-031 Simultaneous: req=1111 rises one cycle after reset -> grants 0,1,2,3 in order, done pulses 7 cycles apart (HOLD_CYCLES=4).
REQ-032 Fairness: req[0], req[1] pending; req[0] re-pulses during source 0 HOLD -> order 0,1,0.
REQ-033 Abort: reset during HOLD of source 3 -> route_en and grant drop at once, no done; req held high afterward -> no transfer.
REQ-034 Held level: req[1] high for 50 cycles -> exactly one transfer; dest changed mid-HOLD -> demux_sel unchanged.
